argmax_seq_ctrl: RTL and testbench

Sequencing controller for the per-node class-selection stage of the GCN inference datapath. On `start` it walks every row of the aggregated FM×W×ADJ result memory. For each row it fetches the WEIGHT_COLS dot-product scores through a request/grant read port, selects the index of the largest score, and writes that index to the max-address output memory. It sits between the aggregation result buffer, whose read port is shared and arbitrated, and the final classification output.

---
 rtl/argmax_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_argmax_seq_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_seq_ctrl.sv
// Per-node class selection: walks every aggregated result row, picks the index
// of the largest unsigned score and writes it to the max-address memory.
module argmax_seq_ctrl #(
    parameter int unsigned NUM_NODES         = 6,
    parameter int unsigned WEIGHT_COLS       = 3,
    parameter int unsigned DOT_PROD_WIDTH    = 16,
    parameter int unsigned MAX_ADDRESS_WIDTH = 2,
    parameter int unsigned ROW_BW            = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rd_req,
    output logic [ROW_BW-1:0]                     rd_addr,
    input  logic                                  rd_gnt,
    input  logic [DOT_PROD_WIDTH*WEIGHT_COLS-1:0] rd_data,
    output logic                                  max_wr_en,
    output logic [ROW_BW-1:0]                     max_wr_addr,
    output logic [MAX_ADDRESS_WIDTH-1:0]          max_wr_data
);

    localparam logic [ROW_BW-1:0] LAST_ROW = ROW_BW'(NUM_NODES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        CAPT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                         state;
    state_t                         state_next;
    logic [ROW_BW-1:0]              row;
    logic [ROW_BW-1:0]              row_next;
    logic [DOT_PROD_WIDTH-1:0]      best_c;
    logic [MAX_ADDRESS_WIDTH-1:0]   argmax_c;

    // Argmax over the captured row; strict '>' keeps the lowest index on ties
    always_comb begin
        best_c   = rd_data[DOT_PROD_WIDTH-1:0];
        argmax_c = '0;
        for (int unsigned c = 1; c < WEIGHT_COLS; c++) begin
            if (rd_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] > best_c) begin
                best_c   = rd_data[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH];
                argmax_c = MAX_ADDRESS_WIDTH'(c);
            end
        end
    end

    // State and row-counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            row   <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    // Next-state and row sequencing
    always_comb begin
        state_next = state;
        row_next   = row;
        case (state)
            IDLE: begin
                if (start) begin
                    row_next   = '0;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (rd_gnt) begin
                    state_next = CAPT;
                end
            end
            CAPT: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (row == LAST_ROW) begin
                    state_next = DONE;
                end else begin
                    row_next   = row + ROW_BW'(1);
                    state_next = REQ;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the upcoming state so they align with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            max_wr_en   <= 1'b0;
            max_wr_addr <= '0;
            max_wr_data <= '0;
        end else begin
            busy      <= (state_next != IDLE);
            done      <= (state_next == DONE);
            rd_req    <= (state_next == REQ);
            max_wr_en <= (state_next == WRITE);
            if (state_next == REQ) begin
                rd_addr <= row_next;
            end
            if (state_next == WRITE) begin
                max_wr_addr <= row_next;
            end
            if (state == CAPT) begin
                max_wr_data <= argmax_c;
            end
        end
    end

endmodule

// File: tb/tb_argmax_seq_ctrl.sv
// Self-checking bench for argmax_seq_ctrl: table vectors, grant stalls,
// start/reset corner cases, randomized runs and a 4x4 parameter variant.
`timescale 1ns/1ps
module tb_argmax_seq_ctrl;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 2;
    localparam int unsigned N0  = 6;
    localparam int unsigned C0  = 3;
    localparam int unsigned RB0 = 3;
    localparam int unsigned N1  = 4;
    localparam int unsigned C1  = 4;
    localparam int unsigned RB1 = 2;

    typedef struct {
        int unsigned s[4];
        int          exp;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic              start0 = 1'b0, gnt0 = 1'b0;
    logic              busy0, done0, req0, wen0;
    logic [RB0-1:0]    addr0, waddr0;
    logic [DW*C0-1:0]  data0 = '0;
    logic [AW-1:0]     wdata0;

    logic              start1 = 1'b0, gnt1 = 1'b0;
    logic              busy1, done1, req1, wen1;
    logic [RB1-1:0]    addr1, waddr1;
    logic [DW*C1-1:0]  data1 = '0;
    logic [AW-1:0]     wdata1;

    logic [DW-1:0] mem0 [N0][C0];
    logic [DW-1:0] mem1 [N1][C1];
    int            exp0 [N0];
    int            exp1 [N1];
    vec_t          tbl  [16];

    int n_chk  = 0;
    int n_fail = 0;

    argmax_seq_ctrl #(.NUM_NODES(N0), .WEIGHT_COLS(C0), .DOT_PROD_WIDTH(DW),
                      .MAX_ADDRESS_WIDTH(AW)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
        .rd_req(req0), .rd_addr(addr0), .rd_gnt(gnt0), .rd_data(data0),
        .max_wr_en(wen0), .max_wr_addr(waddr0), .max_wr_data(wdata0)
    );

    argmax_seq_ctrl #(.NUM_NODES(N1), .WEIGHT_COLS(C1), .DOT_PROD_WIDTH(DW),
                      .MAX_ADDRESS_WIDTH(AW)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .rd_req(req1), .rd_addr(addr1), .rd_gnt(gnt1), .rd_data(data1),
        .max_wr_en(wen1), .max_wr_addr(waddr1), .max_wr_data(wdata1)
    );

    always #5 clk = ~clk;

    // Result-buffer models: data returned the cycle after a granted request
    always @(posedge clk) begin
        if (req0 && gnt0)
            for (int c = 0; c < int'(C0); c++) data0[c*DW +: DW] <= mem0[int'(addr0)][c];
        if (req1 && gnt1)
            for (int c = 0; c < int'(C1); c++) data1[c*DW +: DW] <= mem1[int'(addr1)][c];
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: find the maximum value, then the first column holding it
    function automatic int ref_argmax(input int unsigned s[4], input int n);
        int unsigned m = 0;
        for (int i = 0; i < n; i++) if (s[i] > m) m = s[i];
        for (int i = 0; i < n; i++) if (s[i] == m) return i;
        return 0;
    endfunction

    function automatic int unsigned rnd_score();
        return ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3) : $urandom_range(0, 65535);
    endfunction

    task automatic set_vec(input int i, input int unsigned a, b, c, d, input int e);
        tbl[i].s[0] = a; tbl[i].s[1] = b; tbl[i].s[2] = c; tbl[i].s[3] = d;
        tbl[i].exp  = e;
    endtask

    task automatic load0_table(input int base);
        for (int r = 0; r < int'(N0); r++) begin
            for (int c = 0; c < int'(C0); c++) mem0[r][c] = DW'(tbl[base+r].s[c]);
            exp0[r] = tbl[base+r].exp;
        end
    endtask

    task automatic load0_random();
        int unsigned s[4];
        for (int r = 0; r < int'(N0); r++) begin
            s = '{default: 0};
            for (int c = 0; c < int'(C0); c++) begin
                s[c] = rnd_score();
                mem0[r][c] = DW'(s[c]);
            end
            exp0[r] = ref_argmax(s, C0);
        end
    endtask

    // One full pass on dut0; caller is positioned at a falling edge
    task automatic run0(input int stall_row, input int stall_len, input bit rnd,
                        input bit starts_busy, input bit start_at_done, input bit chain);
        int   withheld = 0, nwr = 0, ndone = 0, done_cyc = 0, stalled = 0;
        bit   prev_wait = 1'b0;
        int   prev_addr = 0;
        start0 = 1'b1;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            start0 = (starts_busy && (cyc == 4 || cyc == 10)) ? 1'b1 : 1'b0;
            if (cyc == 1) begin
                check("busy_after_start", int'(busy0), 1);
                check("first_rd_addr", int'(addr0), 0);
            end
            if (prev_wait) begin
                check("hold_rd_req", int'(req0), 1);
                check("hold_rd_addr", int'(addr0), prev_addr);
            end
            if (wen0) begin
                if (nwr < int'(N0)) begin
                    check("wr_addr", int'(waddr0), nwr);
                    check("wr_data", int'(wdata0), exp0[nwr]);
                end
                nwr++;
            end
            if (done0) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = cyc;
                    if (start_at_done) start0 = 1'b1;
                end
            end
            if (ndone > 0 && cyc == done_cyc + 1) begin
                check("busy_fall", int'(busy0), 0);
                if (chain) break;
            end
            if (ndone > 0 && cyc >= done_cyc + 3) break;
            if (req0) begin
                if (rnd) gnt0 = 1'($urandom_range(0, 1));
                else if (int'(addr0) == stall_row && stalled < stall_len) begin
                    gnt0 = 1'b0;
                    stalled++;
                    check("stall_no_write", int'(wen0), 0);
                end else gnt0 = 1'b1;
                if (!gnt0) withheld++;
            end else begin
                gnt0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            prev_wait = req0 && !gnt0;
            prev_addr = int'(addr0);
        end
        check("num_writes", nwr, N0);
        check("num_done", ndone, 1);
        check("done_cycle", done_cyc, 3*N0 + 1 + withheld);
    endtask

    task automatic run1();
        int nwr = 0, done_cyc = 0;
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            gnt1   = 1'b1;
            if (wen1) begin
                if (nwr < int'(N1)) begin
                    check("v_wr_addr", int'(waddr1), nwr);
                    check("v_wr_data", int'(wdata1), exp1[nwr]);
                end
                nwr++;
            end
            if (done1 && done_cyc == 0) done_cyc = cyc;
            if (done_cyc != 0 && cyc >= done_cyc + 2) break;
        end
        check("v_num_writes", nwr, N1);
        check("v_done_cycle", done_cyc, 3*N1 + 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_rd_req"}, int'(req0), 0);
        check({tag, "_rd_addr"}, int'(addr0), 0);
        check({tag, "_wr_en"}, int'(wen0), 0);
        check({tag, "_wr_addr"}, int'(waddr0), 0);
        check({tag, "_wr_data"}, int'(wdata0), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        int unsigned s[4];

        set_vec(0, 10, 5, 3, 0, 0);          set_vec(1, 1, 9, 2, 0, 1);
        set_vec(2, 0, 0, 7, 0, 2);           set_vec(3, 4, 4, 4, 0, 0);
        set_vec(4, 2, 8, 8, 0, 1);           set_vec(5, 65535, 0, 65535, 0, 0);
        set_vec(6, 'h8000, 'h7FFF, 1, 0, 0); set_vec(7, 'h7FFF, 'h8000, 0, 0, 1);
        set_vec(8, 0, 0, 0, 0, 0);           set_vec(9, 1, 2, 2, 0, 1);
        set_vec(10, 65535, 65535, 65534, 0, 0); set_vec(11, 0, 65534, 65535, 0, 2);
        set_vec(12, 3, 7, 7, 9, 3);          set_vec(13, 5, 5, 1, 5, 0);
        set_vec(14, 0, 0, 0, 1, 3);          set_vec(15, 9, 2, 9, 9, 0);

        // Reset state
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        check("reset_busy1", int'(busy1), 0);
        check("reset_wr_en1", int'(wen1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table runs: immediate grant, then a 5-cycle stall on row 2
        load0_table(0);
        run0(-1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        load0_table(6);
        run0(2, 5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Starts while busy and with done ignored; start right after done restarts
        load0_table(0);
        run0(-1, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        run0(-1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset during WRITE of row 3
        @(negedge clk);
        start0 = 1'b1;
        hit = 1'b0;
        for (int cyc = 1; cyc <= 60 && !hit; cyc++) begin
            @(negedge clk);
            start0 = 1'b0;
            gnt0   = 1'b1;
            if (wen0 && int'(waddr0) == 3) hit = 1'b1;
        end
        check("reached_row3_write", int'(hit), 1);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midreset_no_write", int'(wen0), 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_idle_busy", int'(busy0), 0);
            check("post_reset_no_write", int'(wen0), 0);
        end
        run0(-1, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized rows and grant patterns against the reference model
        for (int k = 0; k < 8; k++) begin
            load0_random();
            run0(-1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        // 4-node, 4-column variant: table rows, then random rows
        for (int r = 0; r < int'(N1); r++) begin
            for (int c = 0; c < int'(C1); c++) mem1[r][c] = DW'(tbl[12+r].s[c]);
            exp1[r] = tbl[12+r].exp;
        end
        run1();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < int'(N1); r++) begin
                for (int c = 0; c < int'(C1); c++) begin
                    s[c] = rnd_score();
                    mem1[r][c] = DW'(s[c]);
                end
                exp1[r] = ref_argmax(s, C1);
            end
            run1();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
